// File: rtl/obi_mux_n_to_1.sv
// N-master to 1-slave OBI mux with fixed-priority or round-robin arbitration and in-order response routing.
// Latency: zero-cycle combinational pass-through on request and response channels; earliest response the cycle after grant.
// Backpressure: slave grant is withheld from all masters while the routing FIFO is full and no response pops this cycle.
//
// Ports:
//   clk_i / rst_i          clock, synchronous active-high reset
//   mst_*                  packed per-master OBI request/response channels (master k at slice k)
//   shr_*                  shared slave OBI channel
//   outstanding_o          number of tracked transactions awaiting a response
//   err_unexp_rvalid_o     sticky: slave responded while nothing was outstanding

// Small generic FIFO: combinational head, occupancy counter kept separately
// from the pointers so full and empty are never ambiguous.
module obi_mux_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push_vld,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop,
  output logic [W-1:0]     o_head_dat,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  // Explicit wrap so DEPTH=1 (single-bit pointer) still stays at slot 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_push_vld) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push_vld) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push_vld, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_cnt      = r_cnt;
endmodule

module obi_mux_n_to_1 #(
  parameter int N_MASTERS       = 3,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_RR          = 0,
  parameter int WRITE_RESP      = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_MASTERS-1:0]            mst_req_i,
  output logic [N_MASTERS-1:0]            mst_gnt_o,
  input  logic [N_MASTERS*ADDR_W-1:0]     mst_addr_i,
  input  logic [N_MASTERS-1:0]            mst_we_i,
  input  logic [N_MASTERS*DATA_W/8-1:0]   mst_be_i,
  input  logic [N_MASTERS*DATA_W-1:0]     mst_wdata_i,
  output logic [N_MASTERS-1:0]            mst_rvalid_o,
  output logic [N_MASTERS*DATA_W-1:0]     mst_rdata_o,
  output logic                            shr_req_o,
  input  logic                            shr_gnt_i,
  output logic [ADDR_W-1:0]               shr_addr_o,
  output logic                            shr_we_o,
  output logic [DATA_W/8-1:0]             shr_be_o,
  output logic [DATA_W-1:0]               shr_wdata_o,
  input  logic                            shr_rvalid_i,
  input  logic [DATA_W-1:0]               shr_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                            err_unexp_rvalid_o
);
  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_lock_vld;
  logic [IDX_W-1:0] r_lock_idx;
  logic             r_err;

  logic [IDX_W-1:0] w_fp_idx;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_rr_k;
  logic             w_rr_found;
  logic             w_lock_hold;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_head;
  logic [CNT_W-1:0] w_cnt;
  logic             w_nonempty;
  logic             w_pop;
  logic             w_can_accept;
  logic             w_hs;
  logic             w_push;

  // Fixed priority: scan downwards so the lowest requesting index wins.
  always_comb begin
    w_fp_idx = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (mst_req_i[i]) begin
        w_fp_idx = IDX_W'(i);
      end
    end
  end

  // Round-robin: first requester at or above the pointer, wrapping.
  always_comb begin
    w_rr_idx   = r_rr_ptr;
    w_rr_found = 1'b0;
    w_rr_k     = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_rr_k = IDX_W'((int'(r_rr_ptr) + i) % N_MASTERS);
      if (!w_rr_found && mst_req_i[w_rr_k]) begin
        w_rr_idx   = w_rr_k;
        w_rr_found = 1'b1;
      end
    end
  end

  // A stalled address phase keeps its master selected so the slave sees
  // stable signals; it is dropped if that master withdraws its request.
  assign w_lock_hold = r_lock_vld && mst_req_i[r_lock_idx];
  assign w_sel       = w_lock_hold ? r_lock_idx : ((ARB_RR != 0) ? w_rr_idx : w_fp_idx);

  assign w_nonempty   = (w_cnt != '0);
  assign w_pop        = !rst_i && shr_rvalid_i && w_nonempty;
  // A response popping this cycle frees a slot, so a full FIFO may still accept.
  assign w_can_accept = (w_cnt < CNT_W'(MAX_OUTSTANDING)) || (shr_rvalid_i && w_nonempty);

  assign shr_req_o   = !rst_i && mst_req_i[w_sel];
  assign shr_addr_o  = mst_addr_i[int'(w_sel)*ADDR_W +: ADDR_W];
  assign shr_we_o    = mst_we_i[w_sel];
  assign shr_be_o    = mst_be_i[int'(w_sel)*BE_W +: BE_W];
  assign shr_wdata_o = mst_wdata_i[int'(w_sel)*DATA_W +: DATA_W];

  assign w_hs   = shr_req_o && shr_gnt_i && w_can_accept;
  // Untracked writes never get a response, so they must not occupy a slot.
  assign w_push = w_hs && (!mst_we_i[w_sel] || (WRITE_RESP != 0));

  always_comb begin
    mst_gnt_o        = '0;
    mst_gnt_o[w_sel] = w_hs;
  end

  always_comb begin
    mst_rvalid_o = '0;
    mst_rdata_o  = '0;
    if (w_pop) begin
      mst_rvalid_o[w_head]                        = 1'b1;
      mst_rdata_o[int'(w_head)*DATA_W +: DATA_W] = shr_rdata_i;
    end
  end

  obi_mux_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W),
    .CNT_W (CNT_W)
  ) u_route_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_push_vld (w_push),
    .i_push_dat (w_sel),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_cnt      (w_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr_ptr <= (w_sel == IDX_W'(N_MASTERS - 1)) ? '0 : w_sel + 1'b1;
      end
      if (shr_req_o && !w_hs) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_sel;
      end else begin
        r_lock_vld <= 1'b0;
      end
      if (shr_rvalid_i && !w_nonempty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding_o      = w_cnt;
  assign err_unexp_rvalid_o = r_err;
endmodule

// File: tb/tb_obi_mux_n_to_1.sv
module tb_obi_mux_n_to_1;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  typedef struct packed {
    logic [1:0]  mst;
    logic [31:0] dat;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: fixed priority, two outstanding, untracked writes
  logic [N-1:0]    a_req, a_we, a_gnt, a_rvalid;
  logic [N*AW-1:0] a_addr;
  logic [N*BW-1:0] a_be;
  logic [N*DW-1:0] a_wdata, a_rdata;
  logic            a_sreq, a_sgnt, a_swe, a_srvalid, a_err;
  logic [AW-1:0]   a_saddr;
  logic [BW-1:0]   a_sbe;
  logic [DW-1:0]   a_swdata, a_srdata;
  logic [1:0]      a_out;

  // Instance B: round-robin, four outstanding, tracked writes
  logic [N-1:0]    b_req, b_we, b_gnt, b_rvalid;
  logic [N*AW-1:0] b_addr;
  logic [N*BW-1:0] b_be;
  logic [N*DW-1:0] b_wdata, b_rdata;
  logic            b_sreq, b_sgnt, b_swe, b_srvalid, b_err;
  logic [AW-1:0]   b_saddr;
  logic [BW-1:0]   b_sbe;
  logic [DW-1:0]   b_swdata, b_srdata;
  logic [2:0]      b_out;

  int    checks = 0;
  int    errors = 0;
  resp_t sb_a[$];
  resp_t sb_b[$];
  resp_t ea, eb;
  logic [N*DW-1:0] eva, evb;

  obi_mux_n_to_1 #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(2),
                   .ARB_RR(0), .WRITE_RESP(0)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .mst_req_i(a_req), .mst_gnt_o(a_gnt), .mst_addr_i(a_addr), .mst_we_i(a_we),
    .mst_be_i(a_be), .mst_wdata_i(a_wdata), .mst_rvalid_o(a_rvalid), .mst_rdata_o(a_rdata),
    .shr_req_o(a_sreq), .shr_gnt_i(a_sgnt), .shr_addr_o(a_saddr), .shr_we_o(a_swe),
    .shr_be_o(a_sbe), .shr_wdata_o(a_swdata), .shr_rvalid_i(a_srvalid), .shr_rdata_i(a_srdata),
    .outstanding_o(a_out), .err_unexp_rvalid_o(a_err)
  );

  obi_mux_n_to_1 #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4),
                   .ARB_RR(1), .WRITE_RESP(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .mst_req_i(b_req), .mst_gnt_o(b_gnt), .mst_addr_i(b_addr), .mst_we_i(b_we),
    .mst_be_i(b_be), .mst_wdata_i(b_wdata), .mst_rvalid_o(b_rvalid), .mst_rdata_o(b_rdata),
    .shr_req_o(b_sreq), .shr_gnt_i(b_sgnt), .shr_addr_o(b_saddr), .shr_we_o(b_swe),
    .shr_be_o(b_sbe), .shr_wdata_o(b_swdata), .shr_rvalid_i(b_srvalid), .shr_rdata_i(b_srdata),
    .outstanding_o(b_out), .err_unexp_rvalid_o(b_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_a(input int m, input logic [31:0] d);
    resp_t e;
    e.mst = 2'(m);
    e.dat = d;
    sb_a.push_back(e);
  endtask

  task automatic exp_b(input int m, input logic [31:0] d);
    resp_t e;
    e.mst = 2'(m);
    e.dat = d;
    sb_b.push_back(e);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Response monitors: every master-side rvalid must match the oldest expected response.
  always @(negedge clk) begin
    if (a_rvalid != '0) begin
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_rvalid actual=%b required=000", a_rvalid);
      end else begin
        ea  = sb_a.pop_front();
        eva = '0;
        eva[ea.mst*DW +: DW] = ea.dat;
        check("a_rvalid_route", a_rvalid, N'(1) << ea.mst);
        check("a_rdata", a_rdata, eva);
      end
    end
  end

  always @(negedge clk) begin
    if (b_rvalid != '0) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_rvalid actual=%b required=000", b_rvalid);
      end else begin
        eb  = sb_b.pop_front();
        evb = '0;
        evb[eb.mst*DW +: DW] = eb.dat;
        check("b_rvalid_route", b_rvalid, N'(1) << eb.mst);
        check("b_rdata", b_rdata, evb);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with every input active: outputs must be gated, err must not set.
    a_req = '1; a_we = '0; a_addr = '0; a_be = '1; a_wdata = '0;
    a_sgnt = 1'b1; a_srvalid = 1'b1; a_srdata = 32'h1234_5678;
    b_req = '1; b_we = '0; b_addr = '0; b_be = '1; b_wdata = '0;
    b_sgnt = 1'b1; b_srvalid = 1'b1; b_srdata = 32'h1234_5678;
    rst = 1'b1;
    to_neg();
    check("rst_a_gnt", a_gnt, 0);
    check("rst_a_sreq", a_sreq, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_b_sreq", b_sreq, 0);
    nxt();
    rst = 1'b0;
    a_req = '0; a_sgnt = 1'b0; a_srvalid = 1'b0;
    b_req = '0; b_sgnt = 1'b0; b_srvalid = 1'b0;
    to_neg();
    check("rst_a_out", a_out, 0);
    check("rst_a_err", a_err, 0);
    check("rst_b_out", b_out, 0);
    check("rst_b_err", b_err, 0);
    nxt();

    // Round-robin: all masters hold req, slave always grants, responds next cycle.
    b_addr[0*AW +: AW] = 32'h1000;
    b_addr[1*AW +: AW] = 32'h1100;
    b_addr[2*AW +: AW] = 32'h1200;
    b_we = 3'b010;
    b_req = 3'b111;
    b_sgnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_srvalid = (k > 0);
      b_srdata  = 32'hB000_0000 | 32'(k - 1);
      exp_b(k % 3, 32'hB000_0000 | 32'(k));
      to_neg();
      check("b_rr_gnt", b_gnt, N'(1) << (k % 3));
      check("b_swe", b_swe, ((k % 3) == 1) ? 1 : 0);
      check("b_out", b_out, (k == 0) ? 0 : 1);
      nxt();
    end
    b_req = '0;
    b_srvalid = 1'b1;
    b_srdata = 32'hB000_0005;
    to_neg();
    check("b_out_tail", b_out, 1);
    nxt();
    b_srvalid = 1'b0;
    b_sgnt = 1'b0;
    to_neg();
    check("b_out_drain", b_out, 0);
    nxt();

    // Fixed priority: masters 0 and 2 read together.
    a_addr[0*AW +: AW] = 32'h10;
    a_addr[2*AW +: AW] = 32'h30;
    a_req = 3'b101;
    a_sgnt = 1'b1;
    exp_a(0, 32'hAAAA_0000);
    exp_a(2, 32'hBBBB_0000);
    to_neg();
    check("fp_gnt0", a_gnt, 3'b001);
    check("fp_addr0", a_saddr, 32'h10);
    check("fp_out0", a_out, 0);
    nxt();
    a_req = 3'b100;
    a_srvalid = 1'b1;
    a_srdata = 32'hAAAA_0000;
    to_neg();
    check("fp_gnt2", a_gnt, 3'b100);
    check("fp_addr2", a_saddr, 32'h30);
    check("fp_out1", a_out, 1);
    nxt();
    a_req = '0;
    a_srdata = 32'hBBBB_0000;
    to_neg();
    check("fp_out2", a_out, 1);
    nxt();
    a_srvalid = 1'b0;
    a_sgnt = 1'b0;
    to_neg();
    check("fp_out_drain", a_out, 0);
    nxt();

    // Lock: master 1 stalls three cycles, master 0 arrives during the stall.
    a_addr[1*AW +: AW] = 32'h100;
    a_addr[0*AW +: AW] = 32'h200;
    a_req = 3'b010;
    exp_a(1, 32'h1111_0000);
    exp_a(0, 32'h2222_0000);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) a_req = 3'b011;
      to_neg();
      check("lock_addr", a_saddr, 32'h100);
      check("lock_gnt", a_gnt, 3'b000);
      check("lock_sreq", a_sreq, 1);
      nxt();
    end
    a_sgnt = 1'b1;
    to_neg();
    check("lock_gnt1", a_gnt, 3'b010);
    check("lock_addr1", a_saddr, 32'h100);
    nxt();
    a_req = 3'b001;
    to_neg();
    check("lock_gnt0", a_gnt, 3'b001);
    check("lock_addr0", a_saddr, 32'h200);
    check("lock_out1", a_out, 1);
    nxt();
    a_req = '0;
    a_srvalid = 1'b1;
    a_srdata = 32'h1111_0000;
    to_neg();
    check("lock_out2", a_out, 2);
    nxt();
    a_srdata = 32'h2222_0000;
    to_neg();
    check("lock_out3", a_out, 1);
    nxt();
    a_srvalid = 1'b0;
    a_sgnt = 1'b0;
    to_neg();
    check("lock_out_drain", a_out, 0);
    nxt();

    // Full FIFO: three back-to-back reads with two slots, first rvalid 5 cycles late.
    a_sgnt = 1'b1;
    a_req = 3'b001;
    a_addr[0*AW +: AW] = 32'h40;
    exp_a(0, 32'hC0);
    exp_a(0, 32'hC1);
    exp_a(0, 32'hC2);
    to_neg();
    check("full_gnt_a", a_gnt, 3'b001);
    check("full_out_a", a_out, 0);
    nxt();
    a_addr[0*AW +: AW] = 32'h44;
    to_neg();
    check("full_gnt_b", a_gnt, 3'b001);
    check("full_out_b", a_out, 1);
    nxt();
    a_addr[0*AW +: AW] = 32'h48;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      check("full_gnt_masked", a_gnt, 3'b000);
      check("full_sreq", a_sreq, 1);
      check("full_out_peak", a_out, 2);
      nxt();
    end
    a_srvalid = 1'b1;
    a_srdata = 32'hC0;
    to_neg();
    check("full_gnt_on_pop", a_gnt, 3'b001);
    check("full_addr_on_pop", a_saddr, 32'h48);
    check("full_out_pushpop", a_out, 2);
    nxt();
    a_req = '0;
    a_srdata = 32'hC1;
    to_neg();
    check("full_out_after", a_out, 2);
    nxt();
    a_srdata = 32'hC2;
    to_neg();
    check("full_out_last", a_out, 1);
    nxt();
    a_srvalid = 1'b0;
    to_neg();
    check("full_out_drain", a_out, 0);
    nxt();

    // Untracked write from master 1, then read from master 0.
    a_addr[1*AW +: AW] = 32'h500;
    a_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    a_be[1*BW +: BW] = 4'h3;
    a_we = 3'b010;
    a_req = 3'b010;
    exp_a(0, 32'h600D);
    to_neg();
    check("wr_gnt", a_gnt, 3'b010);
    check("wr_swe", a_swe, 1);
    check("wr_wdata", a_swdata, 32'hDEAD_BEEF);
    check("wr_be", a_sbe, 4'h3);
    check("wr_out", a_out, 0);
    nxt();
    a_we = '0;
    a_req = 3'b001;
    a_addr[0*AW +: AW] = 32'h600;
    to_neg();
    check("rd_gnt", a_gnt, 3'b001);
    check("rd_swe", a_swe, 0);
    check("wr_not_tracked", a_out, 0);
    nxt();
    a_req = '0;
    a_srvalid = 1'b1;
    a_srdata = 32'h600D;
    to_neg();
    check("rd_out", a_out, 1);
    nxt();
    a_srvalid = 1'b0;
    to_neg();
    check("rd_out_drain", a_out, 0);
    nxt();

    // Reset with two reads outstanding; the late response is unexpected.
    a_req = 3'b101;
    nxt();
    a_req = 3'b100;
    nxt();
    a_req = '0;
    a_sgnt = 1'b0;
    rst = 1'b1;
    to_neg();
    check("mid_out_before_rst", a_out, 2);
    nxt();
    rst = 1'b0;
    a_srvalid = 1'b1;
    a_srdata = 32'h0BAD;
    to_neg();
    check("late_rvalid", a_rvalid, 3'b000);
    check("late_out", a_out, 0);
    check("late_err_pre", a_err, 0);
    nxt();
    a_srvalid = 1'b0;
    to_neg();
    check("late_err", a_err, 1);
    nxt();
    to_neg();
    check("late_err_sticky", a_err, 1);
    check("late_out_zero", a_out, 0);
    nxt();

    check("a_sb_empty", sb_a.size(), 0);
    check("b_sb_empty", sb_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
